// File: rtl/bin_scatter_ctrl.sv
// Load controller for a scatter datapath: accepts up to NUM words and writes them
// to slots 0..len-1 in order, with a registered one-hot strobe and a broadcast data bus.
module bin_scatter_ctrl #(
  parameter int NUM   = 8,
  parameter int WIDTH = 5,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  input  logic             data_valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             data_ready_o,
  output logic [NUM-1:0]   wr_o,
  output logic [WIDTH-1:0] data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] cnt_o,
  output logic             err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [LEN_W-1:0] NUM_L    = LEN_W'(NUM);
  localparam logic [NUM-1:0]   SLOT0_OH = NUM'(1);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] cnt_q;
  logic             err_q;
  logic             vld_p0;
  logic             last_p0;
  logic [NUM-1:0]   wr_p1;
  logic [WIDTH-1:0] data_p1;

  // Requested lengths beyond the slot count are clamped to NUM.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] req);
    return (req > NUM_L) ? NUM_L : req;
  endfunction

  assign data_ready_o = (state == LOAD) && !abort_i;
  assign vld_p0       = data_valid_i && data_ready_o;
  assign last_p0      = (idx_q == len_q - LEN_W'(1));
  assign busy_o       = (state == LOAD);
  assign done_o       = (state == DONE);
  assign cnt_o        = cnt_q;
  assign err_o        = err_q;
  assign wr_o         = wr_p1;
  assign data_o       = data_p1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_i) state_nxt = (len_i == '0) ? DONE : LOAD;
      LOAD: begin
        if (abort_i)                state_nxt = IDLE;
        else if (vld_p0 && last_p0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && start_i) begin
      len_q <= sat_len(len_i);
      idx_q <= '0;
      cnt_q <= '0;
      err_q <= (len_i > NUM_L);
    end else if (vld_p0) begin
      idx_q <= idx_q + LEN_W'(1);
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  // Stage p0 -> p1: accepted word and its slot strobe become visible one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_p1   <= '0;
      data_p1 <= '0;
    end else begin
      wr_p1 <= vld_p0 ? (SLOT0_OH << idx_q) : '0;
      if (vld_p0) data_p1 <= data_i;
    end
  end

endmodule

// File: tb/tb_bin_scatter_ctrl.sv
// Self-checking bench for bin_scatter_ctrl: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the load sequence.
module tb_bin_scatter_ctrl;

  localparam int NUM   = 8;
  localparam int WIDTH = 5;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             abort_i;
  logic             data_valid_i;
  logic [WIDTH-1:0] data_i;
  logic             data_ready_o;
  logic [NUM-1:0]   wr_o;
  logic [WIDTH-1:0] data_o;
  logic             busy_o;
  logic             done_o;
  logic [LEN_W-1:0] cnt_o;
  logic             err_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 loading, 2 completion cycle.
  int m_phase  = 0;
  int m_target = 0;
  int m_filled = 0;
  int m_err    = 0;
  int m_strobe = 0;
  int m_word   = 0;

  bin_scatter_ctrl #(.NUM(NUM), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_ready_o(data_ready_o),
    .wr_o(wr_o), .data_o(data_o), .busy_o(busy_o), .done_o(done_o),
    .cnt_o(cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input int l, input bit a,
                              input bit v, input int d);
    m_strobe = 0;
    if (r) begin
      m_phase = 0; m_target = 0; m_filled = 0; m_err = 0; m_word = 0;
    end else begin
      case (m_phase)
        0: if (s) begin
          m_filled = 0;
          m_err    = (l > NUM) ? 1 : 0;
          m_target = (l > NUM) ? NUM : l;
          m_phase  = (l == 0) ? 2 : 1;
        end
        1: if (a) m_phase = 0;
           else if (v) begin
             m_strobe = 1 << m_filled;
             m_word   = d;
             m_filled++;
             if (m_filled == m_target) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: drive inputs, check combinational ready mid-cycle, then registered outputs.
  task automatic step(input bit r, input bit s, input int l, input bit a,
                      input bit v, input int d);
    rst = r; start_i = s; len_i = LEN_W'(l); abort_i = a;
    data_valid_i = v; data_i = WIDTH'(d);
    @(negedge clk);
    check_eq("data_ready", data_ready_o, (m_phase == 1 && !a) ? 1 : 0);
    @(posedge clk);
    model_update(r, s, l, a, v, d);
    #1;
    check_eq("wr", wr_o, m_strobe);
    check_eq("data", data_o, m_word);
    check_eq("busy", busy_o, (m_phase == 1) ? 1 : 0);
    check_eq("done", done_o, (m_phase == 2) ? 1 : 0);
    check_eq("cnt", cnt_o, m_filled);
    check_eq("err", err_o, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; start_i = 0; len_i = '0; abort_i = 0; data_valid_i = 0; data_i = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 1, 7);
    idle(2);

    // len=3, three back-to-back words
    step(0, 1, 3, 0, 0, 0);
    step(0, 0, 0, 0, 1, 'h11);
    step(0, 0, 0, 0, 1, 'h12);
    step(0, 0, 0, 0, 1, 'h13);
    idle(3);

    // len=8, valid every other cycle
    step(0, 1, 8, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, i[0], i + 3);
    idle(3);

    // over-length request is clamped and flagged until the next start
    step(0, 1, 12, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 20 + i);
    idle(3);
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 2);
    idle(2);

    // zero length finishes immediately
    step(0, 1, 0, 0, 1, 9);
    idle(3);

    // abort after two words with valid held high, then an immediate restart
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 4);
    step(0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 1, 1, 6);
    step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 30);
    idle(2);

    // start during LOAD is ignored; reset mid-LOAD drops the sequence
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10);
    step(0, 1, 2, 0, 1, 11);
    step(0, 1, 7, 0, 0, 0);
    step(1, 0, 0, 0, 1, 12);
    idle(3);

    // abort outside LOAD has no effect
    step(0, 0, 0, 1, 1, 13);
    step(0, 1, 2, 1, 0, 0);
    idle(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 31)));
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
